// File: rtl/brick_field.sv
// Writable brick-map store: loads a stage from ROM, serves row reads and ball hits.
// Optional BRICK_MULTIHIT_EN makes the second-highest brick type a two-hit brick.
module brick_field #(
   parameter  int COLS    = 10,
   parameter  int ROWS    = 30,
   parameter  int TYPE_W  = 3,
   parameter  int ADDR_W  = 5,
   parameter  int STAGE_W = 2,
   localparam int CNT_W   = $clog2(ROWS*COLS+1),
   localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int ROW_W   = COLS*TYPE_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_req,
   input  logic [STAGE_W-1:0] load_stage,
   output logic               busy,
   output logic               load_done,
   output logic               rom_en,
   output logic [STAGE_W-1:0] rom_stage,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [ROW_W-1:0]   rom_data,
   input  logic [ADDR_W-1:0]  rd_row,
   output logic [ROW_W-1:0]   rd_data,
   input  logic               hit_valid,
   input  logic [ADDR_W-1:0]  hit_row,
   input  logic [COL_W-1:0]   hit_col,
   output logic               hit_ready,
   output logic               hit_resp_valid,
   output logic [TYPE_W-1:0]  hit_type,
   output logic               hit_destroyed,
   output logic [CNT_W-1:0]   bricks_left,
   output logic               stage_clear
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [TYPE_W-1:0] EMPTY     = {TYPE_W{1'b0}};
   localparam logic [TYPE_W-1:0] SOLID     = {TYPE_W{1'b1}};
   localparam logic [TYPE_W-1:0] TYPE_ONE  = {{(TYPE_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS-1);
`ifdef BRICK_MULTIHIT_EN
   localparam logic [TYPE_W-1:0] TWO_HIT   = SOLID - TYPE_ONE;
   localparam logic [TYPE_W-1:0] WEAKENED  = TWO_HIT - TYPE_ONE;
`endif

   state_t             state_r;
   logic [ROW_W-1:0]   mem_r [ROWS];
   logic               cap_en_r;
   logic [ADDR_W-1:0]  cap_addr_r;
   logic               loaded_r;

   logic               hit_accept_s;
   logic               hit_in_range_s;
   logic               hit_destroy_s;
   logic               hit_write_s;
   logic [TYPE_W-1:0]  hit_cell_s;
   logic [TYPE_W-1:0]  hit_cell_new_s;
   logic [ROW_W-1:0]   hit_row_old_s;
   logic [ROW_W-1:0]   hit_row_new_s;

   function automatic logic is_destructible(input logic [TYPE_W-1:0] t);
      return (t != EMPTY) && (t != SOLID);
   endfunction

   function automatic logic [CNT_W-1:0] row_count(input logic [ROW_W-1:0] row);
      logic [CNT_W-1:0] n;
      n = {CNT_W{1'b0}};
      for (int c = 0; c < COLS; c++) begin
         if (is_destructible(row[(COLS-1-c)*TYPE_W +: TYPE_W])) begin
            n = n + CNT_ONE;
         end
      end
      return n;
   endfunction

   assign hit_ready    = ~busy & ~load_req;
   assign hit_accept_s = hit_valid & hit_ready;
   assign stage_clear  = loaded_r & (bricks_left == {CNT_W{1'b0}});

   // Look up the hit cell and compute its replacement row; out-of-range hits see an empty cell.
   always_comb begin
      hit_in_range_s = (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
      hit_row_old_s  = {ROW_W{1'b0}};
      hit_cell_s     = EMPTY;
      hit_cell_new_s = EMPTY;
      hit_destroy_s  = 1'b0;
      hit_write_s    = 1'b0;
      if (hit_in_range_s) begin
         hit_row_old_s = mem_r[hit_row];
         hit_cell_s    = hit_row_old_s[(COLS-1-int'(hit_col))*TYPE_W +: TYPE_W];
      end else begin
         hit_row_old_s = {ROW_W{1'b0}};
         hit_cell_s    = EMPTY;
      end
      if (is_destructible(hit_cell_s)) begin
         hit_write_s = 1'b1;
`ifdef BRICK_MULTIHIT_EN
         if (hit_cell_s == TWO_HIT) begin
            hit_cell_new_s = WEAKENED;
            hit_destroy_s  = 1'b0;
         end else begin
            hit_cell_new_s = EMPTY;
            hit_destroy_s  = 1'b1;
         end
`else
         hit_cell_new_s = EMPTY;
         hit_destroy_s  = 1'b1;
`endif
      end else begin
         hit_write_s    = 1'b0;
         hit_cell_new_s = hit_cell_s;
         hit_destroy_s  = 1'b0;
      end
      hit_row_new_s = hit_row_old_s;
      if (hit_in_range_s) begin
         hit_row_new_s[(COLS-1-int'(hit_col))*TYPE_W +: TYPE_W] = hit_cell_new_s;
      end else begin
         hit_row_new_s = hit_row_old_s;
      end
   end

   // Load FSM, ROM capture pipeline, hit updates and registered row read.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r        <= IDLE;
         busy           <= 1'b0;
         load_done      <= 1'b0;
         rom_en         <= 1'b0;
         rom_addr       <= {ADDR_W{1'b0}};
         rom_stage      <= {STAGE_W{1'b0}};
         cap_en_r       <= 1'b0;
         cap_addr_r     <= {ADDR_W{1'b0}};
         loaded_r       <= 1'b0;
         bricks_left    <= {CNT_W{1'b0}};
         rd_data        <= {ROW_W{1'b0}};
         hit_resp_valid <= 1'b0;
         hit_type       <= EMPTY;
         hit_destroyed  <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            mem_r[r] <= {ROW_W{1'b0}};
         end
      end else begin
         load_done  <= 1'b0;
         // ROM answers one cycle after the request, so delay the address to pair it with its data.
         cap_en_r   <= rom_en;
         cap_addr_r <= rom_addr;
         if (cap_en_r) begin
            mem_r[cap_addr_r] <= rom_data;
            bricks_left       <= bricks_left + row_count(rom_data);
         end

         case (state_r)
            IDLE: begin
               if (load_req) begin
                  state_r     <= FETCH;
                  busy        <= 1'b1;
                  rom_en      <= 1'b1;
                  rom_addr    <= {ADDR_W{1'b0}};
                  rom_stage   <= load_stage;
                  bricks_left <= {CNT_W{1'b0}};
                  loaded_r    <= 1'b0;
               end
            end
            FETCH: begin
               if (rom_addr == LAST_ADDR) begin
                  state_r <= DRAIN;
                  rom_en  <= 1'b0;
               end else begin
                  rom_addr <= rom_addr + ADDR_ONE;
               end
            end
            DRAIN: begin
               state_r   <= IDLE;
               busy      <= 1'b0;
               load_done <= 1'b1;
               loaded_r  <= 1'b1;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               rom_en  <= 1'b0;
            end
         endcase

         hit_resp_valid <= hit_accept_s;
         if (hit_accept_s) begin
            hit_type      <= hit_cell_s;
            hit_destroyed <= hit_destroy_s;
            if (hit_write_s) begin
               mem_r[hit_row] <= hit_row_new_s;
            end
            if (hit_destroy_s && (bricks_left != {CNT_W{1'b0}})) begin
               bricks_left <= bricks_left - CNT_ONE;
            end
         end

         if (int'(rd_row) < ROWS) begin
            rd_data <= mem_r[rd_row];
         end else begin
            rd_data <= {ROW_W{1'b0}};
         end
      end
   end

endmodule

// File: doc/brick_field.md
# brick_field

Parametrised, writable brick-map store for the playfield. On request it copies one stage's layout row by row from the stage ROM into an internal register array and counts the destructible bricks. It then serves renderer row reads and ball-collision hits, clearing or degrading the hit bricks and reporting when the stage has been cleared. It sits between the stage ROM and the collision and render logic, and replaces direct ROM reads for the live playfield.

## Interface
Parameters:
- COLS, 10, bricks per row.
- ROWS, 30, rows per stage; must be ≤ 2^ADDR_W.
- TYPE_W, 3, bits per brick type.
- ADDR_W, 5, row address width.
- STAGE_W, 2, stage select width.
- Local CNT_W = $clog2(ROWS*COLS+1).

Ports:
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- load_req  in  1  start a stage load; accepted only while idle.
- load_stage  in  STAGE_W  stage to load; sampled on acceptance.
- busy  out  1  load in progress.
- load_done  out  1  one-cycle pulse when a load completes.
- rom_en, rom_stage, rom_addr  out  1/STAGE_W/ADDR_W  stage ROM request; the ROM returns data one cycle later.
- rom_data  in  COLS*TYPE_W  ROM row; column 0 in the MSBs.
- rd_row  in  ADDR_W  renderer row select.
- rd_data  out  COLS*TYPE_W  registered row contents; column 0 in the MSBs.
- hit_valid, hit_row, hit_col  in  1/ADDR_W/$clog2(COLS)  collision hit request.
- hit_ready  out  1  equals ~busy & ~load_req.
- hit_resp_valid, hit_type, hit_destroyed  out  1/TYPE_W/1  hit result.
- bricks_left  out  CNT_W  remaining destructible bricks.
- stage_clear  out  1  high while loaded and bricks_left == 0.

## Operation
- Brick types: 0 = empty; all-ones (3'b111) = indestructible; every other value is destructible.
- The FSM has three states: IDLE, FETCH, DRAIN.
- IDLE to FETCH on load_req. On entry the block latches load_stage, zeroes bricks_left, and clears the loaded flag.
- FETCH issues rom_addr 0..ROWS-1 on consecutive cycles with rom_en high.
- Each returned row is written to the array at its row index. The popcount of the row's destructible cells is added to bricks_left.
- After the last address, FETCH moves to DRAIN for one cycle to capture the final row, then returns to IDLE.
- On the return to IDLE, load_done pulses and the loaded flag is set.
- load_req while busy is ignored.
- Hit, accepted when hit_valid & hit_ready:
  - Empty or indestructible cell: no change.
  - Destructible cell: cleared to 0, and bricks_left decrements.
  - hit_resp_valid, hit_type and hit_destroyed appear the next cycle. hit_type is the pre-hit value.
- Out-of-range hit (hit_row ≥ ROWS or hit_col ≥ COLS): no state change. The response reports hit_type 0 and hit_destroyed 0.
- load_req and hit_valid in the same cycle: the load wins, because hit_ready is low. The hit is not accepted.
- Row reads: rd_data reflects the array as of the previous edge. During a load it may show partially loaded rows.
- bricks_left never underflows. A decrement at 0 saturates.

## Timing
- Reset values: array all 0, busy 0, load_done 0, rom_en 0, rom_addr 0, rom_stage 0, rd_data 0, hit_resp_valid 0, hit_type 0, hit_destroyed 0, bricks_left 0, loaded 0, FSM in IDLE.
- A reset mid-load aborts the load and restores all reset values.
- Load accepted at edge E0:
  - rom_en is high for cycles E0+1 through E0+ROWS.
  - busy is high for ROWS+1 cycles.
  - load_done pulses in the first cycle after busy falls.
  - bricks_left is final when load_done is high.
- Row read latency: 1 cycle. Hit response latency: 1 cycle.
- Back-to-back hits on the same cell: the second hit sees the updated value.

## Configuration
- BRICK_MULTIHIT_EN defined: type 3'b110 is a two-hit brick.
  - First hit rewrites it to 3'b101, with hit_destroyed 0 and bricks_left unchanged.
  - Second hit clears it normally.
- BRICK_MULTIHIT_EN undefined: 3'b110 is cleared on the first hit like any destructible type.

## Test plan
- Reset, then load stage 0 from the stage ROM model → busy for 31 cycles, a single load_done pulse, bricks_left = 28, row 0 reads all 3'b111.
- After that load, hit row 0 col 0 → hit_type 3'b111, hit_destroyed 0, bricks_left stays 28.
- Hit row 6 col 0 → hit_type 3'b010, destroyed 1, bricks_left 27. Repeat the same hit → hit_type 0, destroyed 0.
- Hit row 31 or col 12 → response with hit_type 0 and no state change. Also check that hit_valid during busy is never accepted.
- Load stage 2 with BRICK_MULTIHIT_EN defined. Hit row 1 col 2 twice → first response 3'b110/destroyed 0, cell reads 3'b101; second response 3'b101/destroyed 1.
- Assert reset at FETCH cycle 10 → next cycle all outputs are at reset values. A new load then completes normally, and stage_clear goes high after every destructible brick has been hit.
